// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared timing defaults and FSM state type for the raster generator
package video_pkg;

    localparam int DEF_DW       = 8;
    localparam int DEF_NCH      = 3;
    localparam int DEF_CW       = 12;
    localparam int DEF_H_SYNC   = 12;
    localparam int DEF_H_BACK   = 40;
    localparam int DEF_H_DISP   = 1936;
    localparam int DEF_H_FRONT  = 28;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BACK   = 18;
    localparam int DEF_V_DISP   = 1088;
    localparam int DEF_V_FRONT  = 3;
    localparam int DEF_REQ_LEAD = 1;
    localparam int MAX_REQ_LEAD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vtg_state_e;

    function automatic int span_total(input int sync_w, input int back_w,
                                      input int disp_w, input int front_w);
        return sync_w + back_w + disp_w + front_w;
    endfunction

endpackage

// File: rtl/video_pipe_delay.sv
// rtl/video_pipe_delay.sv - parametrised reset-clearable shift register for pixel qualifiers
module video_pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with upstream pixel request and output stage
module video_timing_gen
    import video_pkg::*;
#(
    parameter int   DW       = DEF_DW,
    parameter int   NCH      = DEF_NCH,
    parameter int   CW       = DEF_CW,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   H_DISP   = DEF_H_DISP,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter int   V_DISP   = DEF_V_DISP,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   REQ_LEAD = DEF_REQ_LEAD
) (
    input  logic              pixel_clk,
    input  logic              sys_rst_n,
    input  logic              run,
    input  logic [NCH*DW-1:0] pixel_data,
    input  logic              pixel_valid,
    output logic              data_req,
    output logic [CW-1:0]     pixel_x,
    output logic [CW-1:0]     pixel_y,
    output logic              video_hs,
    output logic              video_vs,
    output logic              video_de,
    output logic [NCH*DW-1:0] video_data,
    output logic              frame_start,
    output logic              busy,
    output logic              underrun
);

    localparam int H_TOTAL = span_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam int V_TOTAL = span_total(V_SYNC, V_BACK, V_DISP, V_FRONT);

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
    // Requests run REQ_LEAD+1 pixels ahead of the counter so DE lands one cycle behind it
    localparam logic [CW-1:0] REQ_START = CW'(H_SYNC + H_BACK - REQ_LEAD - 1);
    localparam logic [CW-1:0] REQ_END   = CW'(H_SYNC + H_BACK + H_DISP - REQ_LEAD - 1);
    localparam logic [CW-1:0] VA_START  = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] VA_END    = CW'(V_SYNC + V_BACK + V_DISP);

    if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_chk_width
        $error("video_timing_gen: raster totals do not fit in CW bits");
    end
    if (REQ_LEAD < 0 || REQ_LEAD > MAX_REQ_LEAD) begin : g_chk_lead_range
        $error("video_timing_gen: REQ_LEAD out of range");
    end
    if (H_SYNC + H_BACK < REQ_LEAD + 2) begin : g_chk_lead_room
        $error("video_timing_gen: horizontal blanking too short for REQ_LEAD");
    end

    vtg_state_e        state_q, state_d;
    logic [CW-1:0]     h_q, h_d;
    logic [CW-1:0]     v_q, v_d;
    logic              running;
    logic              line_end;
    logic              frame_end;

    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              fs_q, fs_d;
    logic              req_q, req_d;
    logic [CW-1:0]     px_q, px_d;
    logic [CW-1:0]     py_q, py_d;
    logic              busy_q;
    logic              de_q;
    logic [NCH*DW-1:0] data_q;
    logic              bad_q;
    logic              underrun_q, underrun_d;
    logic              de_sample;

    assign running   = (state_q != IDLE);
    assign line_end  = (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        if (running) begin
            h_d = line_end ? '0 : h_q + CW'(1);
            if (line_end) begin
                v_d = frame_end ? '0 : v_q + CW'(1);
            end
        end
        case (state_q)
            IDLE:    if (run) state_d = RUN;
            RUN:     if (!run) state_d = frame_end ? IDLE : DRAIN;
            DRAIN:   if (frame_end) state_d = run ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hs_d  = (running && (h_q < H_SYNC_C)) ? HS_POL : ~HS_POL;
        vs_d  = (running && (v_q < V_SYNC_C)) ? VS_POL : ~VS_POL;
        fs_d  = running && (h_q == '0) && (v_q == '0);
        req_d = running && (h_q >= REQ_START) && (h_q < REQ_END)
                        && (v_q >= VA_START) && (v_q < VA_END);
        px_d  = req_d ? (h_q - REQ_START) : '0;
        py_d  = req_d ? (v_q - VA_START) : '0;
        // A miss reported by the same cycle that opens a new frame must survive the clear
        underrun_d = underrun_q;
        if (bad_q) begin
            underrun_d = 1'b1;
        end else if (fs_d) begin
            underrun_d = 1'b0;
        end
    end

    video_pipe_delay #(
        .WIDTH (1),
        .DEPTH (REQ_LEAD + 1)
    ) u_de_pipe (
        .clk_i  (pixel_clk),
        .rst_ni (sys_rst_n),
        .data_i (req_d),
        .data_o (de_sample)
    );

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            h_q        <= '0;
            v_q        <= '0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            fs_q       <= 1'b0;
            req_q      <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            busy_q     <= 1'b0;
            de_q       <= 1'b0;
            data_q     <= '0;
            bad_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            v_q        <= v_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            fs_q       <= fs_d;
            req_q      <= req_d;
            px_q       <= px_d;
            py_q       <= py_d;
            busy_q     <= (state_d != IDLE);
            de_q       <= de_sample;
            data_q     <= (de_sample && pixel_valid) ? pixel_data : '0;
            bad_q      <= de_sample && !pixel_valid;
            underrun_q <= underrun_d;
        end
    end

    assign data_req    = req_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign video_hs    = hs_q;
    assign video_vs    = vs_q;
    assign video_de    = de_q;
    assign video_data  = data_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;

endmodule
